// File: rtl/crc_pkg.sv
// Shared CRC32 definitions: word width, checker state encoding and the
// bit-reversal used to turn the LSB-first polynomial into shift-register order.
package crc_pkg;

  localparam int CRC_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    NEXT   = 2'd2,
    REPORT = 2'd3
  } state_e;

  function automatic logic [CRC_W-1:0] reverse32(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational CRC32 division step: folds BITS_PER_CYCLE data bits (MSB first)
// into the remainder, feedback taken from r[31] with an implicit x^32 term.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [CRC_W-1:0]          r_i,
  input  logic [CRC_W-1:0]          poly_i,
  input  logic [BITS_PER_CYCLE-1:0] data_i,
  output logic [CRC_W-1:0]          r_o
);

  logic [CRC_W-1:0] acc;

  always_comb begin
    acc = r_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      acc = {acc[CRC_W-2:0], data_i[BITS_PER_CYCLE-1-i]} ^ ({CRC_W{acc[CRC_W-1]}} & poly_i);
    end
    r_o = acc;
  end

endmodule

// File: rtl/crc32_checker.sv
// Receive-side CRC32 checker: divides a framed word stream (message + CRC word)
// by the latched polynomial and reports the residual syndrome per frame.
module crc32_checker
  import crc_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      polynomial_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  input  logic             in_last_i,
  output logic             done_o,
  output logic             pass_o,
  output logic [31:0]      syndrome_o,
  output logic [CNT_W-1:0] word_count_o
);

  localparam int         STEPS     = CRC_W / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

  state_e           state_q, state_d;
  logic [CRC_W-1:0] r_q, r_d;
  logic [CRC_W-1:0] poly_q, poly_d;
  logic [CRC_W-1:0] word_q, word_d;
  logic [CRC_W-1:0] syn_q, syn_d;
  logic             last_q, last_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [CRC_W-1:0] r_step;

  crc_lfsr_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .r_i   (r_q),
    .poly_i(poly_q),
    .data_i(word_q[CRC_W-1 -: BITS_PER_CYCLE]),
    .r_o   (r_step)
  );

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    poly_d     = poly_q;
    word_d     = word_q;
    syn_d      = syn_q;
    last_d     = last_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    bit_d      = bit_q;
    in_ready_o = (state_q == IDLE) || (state_q == NEXT);
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          r_d     = '0;
          poly_d  = reverse32(polynomial_i);
          word_d  = in_data_i;
          last_d  = in_last_i;
          cnt_d   = CNT_W'(1);
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        r_d    = r_step;
        word_d = word_q << BITS_PER_CYCLE;
        if (bit_q == LAST_STEP) begin
          bit_d   = '0;
          state_d = last_q ? REPORT : NEXT;
        end else begin
          bit_d = bit_q + 5'd1;
        end
      end
      NEXT: begin
        if (in_valid_i) begin
          word_d  = in_data_i;
          last_d  = in_last_i;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = SHIFT;
        end
      end
      REPORT: begin
        // Results are registered here so they appear with the done pulse.
        done_d  = 1'b1;
        syn_d   = r_q;
        pass_d  = (r_q == '0);
        wcnt_d  = cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      r_q     <= '0;
      poly_q  <= '0;
      word_q  <= '0;
      syn_q   <= '0;
      last_q  <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      poly_q  <= poly_d;
      word_q  <= word_d;
      syn_q   <= syn_d;
      last_q  <= last_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      bit_q   <= bit_d;
    end
  end

  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign syndrome_o   = syn_q;
  assign word_count_o = wcnt_q;

endmodule
